// File: rtl/mon_waveform_recorder_if.sv
// Monitor stream, local-bus write port and buffer readback port of the waveform recorder.
interface mon_waveform_recorder_if #(
  parameter int AW = 11,
  parameter int DW = 20
);
  logic signed [DW-1:0] mon_result;
  logic                 mon_strobe;
  logic                 mon_boundary;
  logic [31:0]          lb_data;
  logic [15:0]          lb_addr;
  logic                 lb_write;
  logic [AW-1:0]        buf_addr;
  logic [DW-1:0]        buf_data;

  modport master (
    output mon_result, mon_strobe, mon_boundary, lb_data, lb_addr, lb_write, buf_addr,
    input  buf_data
  );

  modport slave (
    input  mon_result, mon_strobe, mon_boundary, lb_data, lb_addr, lb_write, buf_addr,
    output buf_data
  );
endinterface

// File: rtl/mon_waveform_recorder.sv
// Frame-aligned circular waveform recorder with programmable pre-trigger depth.
// Optional trigger timestamp enabled by defining MON_RECORD_TIMESTAMP_EN.
module mon_waveform_recorder #(
  parameter int          AW      = 11,
  parameter int          DW      = 20,
  parameter logic [15:0] LB_BASE = 16'h2000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mon_waveform_recorder_if.slave bus,
  input  logic                  ext_trig,
  output logic                  armed,
  output logic                  done,
  output logic [AW-1:0]         start_addr,
  output logic [31:0]           trig_time
);
  localparam int          N     = 2 ** AW;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {IDLE, SYNC, PRE, ARMED, POST, DONE} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] pretrig_reg, pretrig_act_reg, pretrig_act_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic [AW:0]   post_cnt_reg, post_cnt_next;
  logic [AW:0]   post_limit;
  logic [AW-1:0] start_addr_reg, start_addr_next;
  logic          armed_reg, armed_next;
  logic          done_reg, done_next;
  logic [2:0]    trig_sync_reg;
  logic          ctrl_wr, pretrig_wr, arm_cmd, soft_trig, abort_cmd;
  logic          ext_edge, trig_ev, trig_accept, mem_we;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] mem_rd_reg;
  logic          unused_lb_bits;

  assign ctrl_wr    = bus.lb_write && (bus.lb_addr == LB_BASE);
  assign pretrig_wr = bus.lb_write && (bus.lb_addr == LB_BASE + 16'd1);
  assign arm_cmd    = ctrl_wr && bus.lb_data[0];
  assign soft_trig  = ctrl_wr && bus.lb_data[1];
  assign abort_cmd  = ctrl_wr && bus.lb_data[2];

  // Bits [1:0] are the synchroniser, bit 2 holds the previous level for edge detection.
  assign ext_edge   = trig_sync_reg[1] && !trig_sync_reg[2];
  assign trig_ev    = ext_edge || soft_trig;
  assign post_limit = DEPTH - {1'b0, pretrig_act_reg};

  assign unused_lb_bits = ^bus.lb_data[31:AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pretrig_reg     <= '0;
      pretrig_act_reg <= '0;
      wr_ptr_reg      <= '0;
      cnt_reg         <= '0;
      post_cnt_reg    <= '0;
      start_addr_reg  <= '0;
      armed_reg       <= 1'b0;
      done_reg        <= 1'b0;
      trig_sync_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      pretrig_act_reg <= pretrig_act_next;
      wr_ptr_reg      <= wr_ptr_next;
      cnt_reg         <= cnt_next;
      post_cnt_reg    <= post_cnt_next;
      start_addr_reg  <= start_addr_next;
      armed_reg       <= armed_next;
      done_reg        <= done_next;
      trig_sync_reg   <= {trig_sync_reg[1:0], ext_trig};
      if (pretrig_wr) begin
        pretrig_reg <= bus.lb_data[AW-1:0];
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    pretrig_act_next = pretrig_act_reg;
    wr_ptr_next      = wr_ptr_reg;
    cnt_next         = cnt_reg;
    post_cnt_next    = post_cnt_reg;
    start_addr_next  = start_addr_reg;
    trig_accept      = 1'b0;
    if (abort_cmd) begin
      state_next = IDLE;
    end else if (arm_cmd) begin
      state_next       = SYNC;
      pretrig_act_next = pretrig_reg;
      wr_ptr_next      = '0;
      cnt_next         = '0;
      post_cnt_next    = '0;
    end else begin
      case (state_reg)
        SYNC: begin
          if (bus.mon_strobe && bus.mon_boundary) begin
            wr_ptr_next = AW'(1);
            cnt_next    = AW'(1);
            state_next  = (pretrig_act_reg == '0) ? ARMED : PRE;
          end
        end
        PRE: begin
          if (bus.mon_strobe) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
            cnt_next    = cnt_reg + AW'(1);
          end
          if (cnt_reg == pretrig_act_reg) begin
            state_next = ARMED;
          end
        end
        ARMED: begin
          if (bus.mon_strobe) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
          end
          // A strobe coincident with acceptance lands at trig_ptr and is the first post sample.
          if (trig_ev) begin
            trig_accept     = 1'b1;
            start_addr_next = wr_ptr_reg - pretrig_act_reg;
            post_cnt_next   = bus.mon_strobe ? (AW+1)'(1) : '0;
            state_next      = (bus.mon_strobe && post_limit == (AW+1)'(1)) ? DONE : POST;
          end
        end
        POST: begin
          if (bus.mon_strobe) begin
            wr_ptr_next   = wr_ptr_reg + AW'(1);
            post_cnt_next = post_cnt_reg + (AW+1)'(1);
            if (post_cnt_reg + (AW+1)'(1) == post_limit) begin
              state_next = DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    armed_next = (state_next == SYNC) || (state_next == PRE) ||
                 (state_next == ARMED) || (state_next == POST);
    done_next  = (state_next == DONE);
    mem_we     = 1'b0;
    if (bus.mon_strobe && !abort_cmd && !arm_cmd) begin
      mem_we = ((state_reg == SYNC) && bus.mon_boundary) || (state_reg == PRE) ||
               (state_reg == ARMED) || (state_reg == POST);
    end
  end

  // Read-before-write: a same-cycle read of the written location returns the old word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_reg] <= bus.mon_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_reg <= '0;
    end else begin
      mem_rd_reg <= mem[bus.buf_addr];
    end
  end

  assign bus.buf_data = mem_rd_reg;
  assign armed        = armed_reg;
  assign done         = done_reg;
  assign start_addr   = start_addr_reg;

`ifdef MON_RECORD_TIMESTAMP_EN
  logic [31:0] ts_cnt_reg;
  logic [31:0] trig_time_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_reg    <= '0;
      trig_time_reg <= '0;
    end else begin
      ts_cnt_reg <= ts_cnt_reg + 32'd1;
      if (arm_cmd && !abort_cmd) begin
        trig_time_reg <= '0;
      end else if (trig_accept) begin
        trig_time_reg <= ts_cnt_reg;
      end
    end
  end

  assign trig_time = trig_time_reg;
`else
  logic unused_trig_accept;
  assign unused_trig_accept = trig_accept;
  assign trig_time          = '0;
`endif
endmodule
